// File: rtl/demux_scheduler.sv
// demux_scheduler
// Round-robin scheduler that shares a 1-to-8 demux between eight requesters.
// One requester is granted at a time; its word is serialised MSB-first on d0
// while the demux selects point at that requester's output.
//
// Parameters:
//   DATA_W  word width in bits (1..16)
//   GAP     idle cycles inserted after each word (0..15)
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   req        per-requester request level, bit i targets demux output i
//   data_flat  requester words, word i = data_flat[i*DATA_W +: DATA_W]
//   ack        one-cycle pulse on bit g once word g has been fully shifted
//   d0         serial data to demux D0
//   s0,s1,s2   demux selects, {s0,s1,s2} = granted index (s0 is the MSB)
//   frame      high while d0 carries a valid payload bit
//   busy       high in every state except IDLE
// All outputs come straight from flops.
module demux_scheduler #(
  parameter int DATA_W = 8,
  parameter int GAP    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            req,
  input  logic [8*DATA_W-1:0]   data_flat,
  output logic [7:0]            ack,
  output logic                  d0,
  output logic                  s0,
  output logic                  s1,
  output logic                  s2,
  output logic                  frame,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [2:0]          ptr_r, ptr_nxt_s;
  logic [2:0]          grant_r, grant_nxt_s;
  logic [2:0]          pick_s;
  logic [DATA_W-1:0]   shreg_r, shreg_nxt_s;
  logic [DATA_W-1:0]   word_s;
  logic [8*DATA_W-1:0] shifted_s;
  logic [3:0]          bitcnt_r, bitcnt_nxt_s;
  logic [3:0]          gapcnt_r, gapcnt_nxt_s;
  logic [7:0]          ack_r, ack_nxt_s;
  logic                d0_r, d0_nxt_s;
  logic                frame_r, frame_nxt_s;
  logic                busy_r, busy_nxt_s;

  // First set request bit scanning ptr, ptr+1, ... modulo 8. The loop runs
  // downwards so the closest requester to ptr is the last (winning) write.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] g;
    g = p;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) begin
        g = idx;
      end else begin
        g = g;
      end
    end
    return g;
  endfunction

  // Grant candidate and the word it would latch.
  always_comb begin
    pick_s    = rr_pick(req, ptr_r);
    shifted_s = data_flat >> (int'(pick_s) * DATA_W);
    word_s    = shifted_s[DATA_W-1:0];
  end

  // Next-state and next-output logic of the scheduler FSM.
  always_comb begin
    state_nxt_s  = state_r;
    ptr_nxt_s    = ptr_r;
    grant_nxt_s  = grant_r;
    shreg_nxt_s  = shreg_r;
    bitcnt_nxt_s = bitcnt_r;
    gapcnt_nxt_s = gapcnt_r;
    ack_nxt_s    = 8'd0;
    d0_nxt_s     = 1'b0;
    frame_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req != 8'd0) begin
          // The MSB goes out on the grant edge itself, so the register keeps
          // only the remaining bits already shifted into position.
          state_nxt_s  = ST_SHIFT;
          grant_nxt_s  = pick_s;
          d0_nxt_s     = word_s[DATA_W-1];
          shreg_nxt_s  = word_s << 1;
          frame_nxt_s  = 1'b1;
          bitcnt_nxt_s = 4'(DATA_W - 1);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bitcnt_r == 4'd0) begin
          // Last payload bit is on d0 now: acknowledge and move the pointer
          // past the winner so it becomes lowest priority.
          state_nxt_s = ST_DONE;
          ack_nxt_s   = 8'd1 << grant_r;
          ptr_nxt_s   = grant_r + 3'd1;
        end else begin
          d0_nxt_s     = shreg_r[DATA_W-1];
          shreg_nxt_s  = shreg_r << 1;
          bitcnt_nxt_s = bitcnt_r - 4'd1;
          frame_nxt_s  = 1'b1;
        end
      end
      ST_DONE: begin
        if (GAP == 0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s  = ST_GAP;
          gapcnt_nxt_s = 4'(GAP - 1);
        end
      end
      ST_GAP: begin
        if (gapcnt_r == 4'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          gapcnt_nxt_s = gapcnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and output registers; reset drops any word in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      ptr_r    <= 3'd0;
      grant_r  <= 3'd0;
      shreg_r  <= '0;
      bitcnt_r <= 4'd0;
      gapcnt_r <= 4'd0;
      ack_r    <= 8'd0;
      d0_r     <= 1'b0;
      frame_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      ptr_r    <= ptr_nxt_s;
      grant_r  <= grant_nxt_s;
      shreg_r  <= shreg_nxt_s;
      bitcnt_r <= bitcnt_nxt_s;
      gapcnt_r <= gapcnt_nxt_s;
      ack_r    <= ack_nxt_s;
      d0_r     <= d0_nxt_s;
      frame_r  <= frame_nxt_s;
      busy_r   <= busy_nxt_s;
    end
  end

  // Selects follow the grant register, which only changes on a grant edge.
  assign s0    = grant_r[2];
  assign s1    = grant_r[1];
  assign s2    = grant_r[0];
  assign ack   = ack_r;
  assign d0    = d0_r;
  assign frame = frame_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_demux_scheduler.sv
// Directed self-checking bench for demux_scheduler: one instance with default
// parameters and one with DATA_W=4, GAP=0.
module tb_demux_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  req   = 8'd0;
  logic [63:0] data_flat = 64'd0;
  logic [7:0]  ack;
  logic        d0, s0, s1, s2, frame, busy;

  logic [7:0]  req2  = 8'd0;
  logic [31:0] data2 = 32'd0;
  logic [7:0]  ack2;
  logic        d0_2, s0_2, s1_2, s2_2, frame2, busy2;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  demux_scheduler dut (
    .clock(clock), .reset(reset), .req(req), .data_flat(data_flat),
    .ack(ack), .d0(d0), .s0(s0), .s1(s1), .s2(s2), .frame(frame), .busy(busy)
  );

  demux_scheduler #(.DATA_W(4), .GAP(0)) dut2 (
    .clock(clock), .reset(reset), .req(req2), .data_flat(data2),
    .ack(ack2), .d0(d0_2), .s0(s0_2), .s1(s1_2), .s2(s2_2), .frame(frame2), .busy(busy2)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] rr_word(input int i);
    return 8'(i * 16 + 15 - i);
  endfunction

  task automatic set_word(input int i, input logic [7:0] w);
    data_flat[i*8 +: 8] = w;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Waits (bounded) for a frame on the default instance and captures it.
  // Returns at the negedge of the ack cycle.
  task automatic get_word(output bit found, output logic [2:0] g, output logic [7:0] w,
                          output logic [7:0] a, output bit stable, output int start);
    found = 1'b0; stable = 1'b1; g = 3'd0; w = 8'd0; a = 8'd0; start = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clock);
      if (frame === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) return;
    start = cyc;
    g = {s0, s1, s2};
    w = {7'd0, d0};
    for (int i = 1; i < 8; i++) begin
      @(negedge clock);
      if (frame !== 1'b1 || {s0, s1, s2} !== g) stable = 1'b0;
      w = {w[6:0], d0};
    end
    @(negedge clock);
    a = ack;
    if (frame !== 1'b0 || d0 !== 1'b0 || {s0, s1, s2} !== g) stable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests_run++;
    if ({ack, d0, s0, s1, s2, frame, busy} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want 0", {ack, d0, s0, s1, s2, frame, busy});
    end
    tests_run++;
    if ({ack2, d0_2, s0_2, s1_2, s2_2, frame2, busy2} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs2: got %b want 0", {ack2, d0_2, s0_2, s1_2, s2_2, frame2, busy2});
    end
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if (busy !== 1'b0 || frame !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: busy=%b frame=%b want 0 0", busy, frame);
    end
  endtask

  task automatic test_single_word();
    bit found, stable; logic [2:0] g; logic [7:0] w, a; int st;
    for (int i = 0; i < 8; i++) set_word(i, 8'hFF);
    set_word(2, 8'hA5);
    req = 8'b0000_0100;
    get_word(found, g, w, a, stable, st);
    req = 8'd0;
    tests_run++;
    if (!found) begin tests_failed++; $display("FAIL single_found: no frame within bound"); end
    tests_run++;
    if (g !== 3'b010) begin tests_failed++; $display("FAIL single_sel: got %b want 010", g); end
    tests_run++;
    if (w !== 8'hA5) begin tests_failed++; $display("FAIL single_bits: got %h want a5", w); end
    tests_run++;
    if (a !== 8'h04) begin tests_failed++; $display("FAIL single_ack: got %h want 04", a); end
    tests_run++;
    if (!stable) begin tests_failed++; $display("FAIL single_frame: frame/sel not held for 8 cycles"); end
    @(negedge clock);
    tests_run++;
    if ({busy, ack, frame, d0} !== {1'b1, 8'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_gap: busy=%b ack=%h frame=%b d0=%b want 1 00 0 0", busy, ack, frame, d0);
    end
    @(negedge clock);
    tests_run++;
    if (busy !== 1'b0 || {s0, s1, s2} !== 3'b010) begin
      tests_failed++;
      $display("FAIL single_idle: busy=%b sel=%b want 0 010", busy, {s0, s1, s2});
    end
  endtask

  task automatic test_round_robin();
    bit found, stable; logic [2:0] g; logic [7:0] w, a; int st, prev;
    do_reset();
    for (int i = 0; i < 8; i++) set_word(i, rr_word(i));
    req = 8'hFF;
    prev = 0;
    for (int k = 0; k < 9; k++) begin
      get_word(found, g, w, a, stable, st);
      if (k == 8) req = 8'd0;
      tests_run++;
      if (!found || g !== 3'(k % 8)) begin
        tests_failed++;
        $display("FAIL rr_grant[%0d]: found=%b got %0d want %0d", k, found, g, k % 8);
      end
      tests_run++;
      if (w !== rr_word(k % 8)) begin
        tests_failed++;
        $display("FAIL rr_word[%0d]: got %h want %h", k, w, rr_word(k % 8));
      end
      tests_run++;
      if (a !== (8'd1 << (k % 8)) || !stable) begin
        tests_failed++;
        $display("FAIL rr_ack[%0d]: got %h stable=%b want %h", k, a, stable, 8'd1 << (k % 8));
      end
      if (k > 0) begin
        tests_run++;
        if (st - prev !== 11) begin
          tests_failed++;
          $display("FAIL rr_period[%0d]: got %0d want 11", k, st - prev);
        end
      end
      prev = st;
    end
    repeat (3) @(negedge clock);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rr_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_wrap();
    bit found, stable; logic [2:0] g; logic [7:0] w, a; int st;
    do_reset();
    set_word(2, 8'h99); set_word(7, 8'hE1); set_word(0, 8'h3C);
    req = 8'h04;
    get_word(found, g, w, a, stable, st);
    req = 8'd0;
    tests_run++;
    if (!found || g !== 3'd2) begin tests_failed++; $display("FAIL wrap_first: got %0d want 2", g); end
    repeat (2) @(negedge clock);
    req = 8'b1000_0001;
    get_word(found, g, w, a, stable, st);
    tests_run++;
    if (!found || g !== 3'd7 || w !== 8'hE1 || a !== 8'h80) begin
      tests_failed++;
      $display("FAIL wrap_grant7: got g=%0d w=%h ack=%h want 7 e1 80", g, w, a);
    end
    get_word(found, g, w, a, stable, st);
    req = 8'd0;
    tests_run++;
    if (!found || g !== 3'd0 || w !== 8'h3C || a !== 8'h01) begin
      tests_failed++;
      $display("FAIL wrap_grant0: got g=%0d w=%h ack=%h want 0 3c 01", g, w, a);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_req_drop();
    logic [7:0] w; bit stable;
    do_reset();
    set_word(5, 8'hC3);
    req = 8'h20;
    @(negedge clock);
    stable = (frame === 1'b1) && ({s0, s1, s2} === 3'd5);
    w = {7'd0, d0};
    for (int i = 1; i < 8; i++) begin
      if (i == 3) begin
        req = 8'd0;
        set_word(5, 8'h3C);
      end
      @(negedge clock);
      if (frame !== 1'b1) stable = 1'b0;
      w = {w[6:0], d0};
    end
    tests_run++;
    if (w !== 8'hC3 || !stable) begin
      tests_failed++;
      $display("FAIL drop_word: got %h stable=%b want c3 1", w, stable);
    end
    @(negedge clock);
    tests_run++;
    if (ack !== 8'h20) begin tests_failed++; $display("FAIL drop_ack: got %h want 20", ack); end
    repeat (2) @(negedge clock);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL drop_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_shift();
    bit found, stable; logic [2:0] g; logic [7:0] w, a; int st;
    do_reset();
    set_word(2, 8'h11); set_word(6, 8'hF0); set_word(0, 8'h5A);
    req = 8'h04;
    get_word(found, g, w, a, stable, st);
    req = 8'd0;
    repeat (2) @(negedge clock);
    req = 8'h40;
    repeat (4) @(negedge clock);
    tests_run++;
    if (frame !== 1'b1 || {s0, s1, s2} !== 3'd6) begin
      tests_failed++;
      $display("FAIL mid_pre: frame=%b sel=%0d want 1 6", frame, {s0, s1, s2});
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({ack, d0, s0, s1, s2, frame, busy} !== 13'd0) begin
      tests_failed++;
      $display("FAIL mid_async: got %b want 0", {ack, d0, s0, s1, s2, frame, busy});
    end
    req = 8'h41;
    @(negedge clock);
    tests_run++;
    if (ack !== 8'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_hold: ack=%h busy=%b want 00 0", ack, busy);
    end
    reset = 1'b0;
    get_word(found, g, w, a, stable, st);
    req = 8'd0;
    tests_run++;
    if (!found || g !== 3'd0 || w !== 8'h5A || a !== 8'h01) begin
      tests_failed++;
      $display("FAIL mid_restart: got g=%0d w=%h ack=%h want 0 5a 01", g, w, a);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_gap0();
    bit found; logic [2:0] g; logic [3:0] w4; logic [7:0] a; int st, prev;
    data2[3:0] = 4'h9;
    data2[7:4] = 4'h6;
    req2 = 8'h03;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clock);
        if (frame2 === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      st = cyc;
      g = {s0_2, s1_2, s2_2};
      w4 = {3'd0, d0_2};
      for (int i = 1; i < 4; i++) begin
        @(negedge clock);
        w4 = {w4[2:0], d0_2};
      end
      @(negedge clock);
      a = ack2;
      if (k == 3) req2 = 8'd0;
      tests_run++;
      if (!found || g !== 3'(k % 2) || w4 !== ((k % 2 == 0) ? 4'h9 : 4'h6)) begin
        tests_failed++;
        $display("FAIL gap0_word[%0d]: found=%b g=%0d w=%h want %0d", k, found, g, w4, k % 2);
      end
      tests_run++;
      if (a !== (8'd1 << (k % 2))) begin
        tests_failed++;
        $display("FAIL gap0_ack[%0d]: got %h want %h", k, a, 8'd1 << (k % 2));
      end
      if (k > 0) begin
        tests_run++;
        if (st - prev !== 6) begin
          tests_failed++;
          $display("FAIL gap0_period[%0d]: got %0d want 6", k, st - prev);
        end
      end
      prev = st;
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_round_robin();
    test_wrap();
    test_req_drop();
    test_reset_mid_shift();
    test_gap0();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
